riscv_test_monitor: RTL and testbench
=====================================

# riscv_test_monitor

Synthesizable, parametrised completion monitor for riscv-tests runs. It replaces the fixed-tick "check gp after N cycles" bench pattern with a cycle-accurate verdict per hart. The block snoops each hart's register writeback port and ecall-retire pulse, keeps a shadow of the result register (gp, x3), and latches PASS/FAIL/TIMEOUT with the failing test number and cycle count. It sits beside `Core` in benches and FPGA builds; its outputs drive the result file and LEDs.

## Interface
- `NHARTS`, 1: number of monitored harts (1..8)
- `XLEN`, 32: register/PC width
- `RESULT_REG`, 3: register index shadowed as the result (gp)
- `TIMEOUT`, 5000: cycles from start before a RUN hart is declared TIMEOUT (≥1)
- `STALL_CYCLES`, 64: consecutive identical-PC cycles that mean a hang (used only with the stall macro)
- `CW`: localparam, `$clog2(TIMEOUT+1)`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; (re)arms every hart
- `wb_en`  in  NHARTS  per-hart register write strobe
- `wb_addr`  in  NHARTS*5  per-hart destination register
- `wb_data`  in  NHARTS*XLEN  per-hart write data
- `ecall`  in  NHARTS  per-hart ecall retire pulse
- `pc`  in  NHARTS*XLEN  per-hart retiring PC (ignored without stall macro)
- `status`  out  NHARTS*3  per-hart state code
- `fail_testnum`  out  NHARTS*(XLEN-1)  shadow >> 1, latched at verdict
- `cycles`  out  NHARTS*CW  cycles from start to verdict
- `all_done`  out  1  every hart in a terminal state
- `all_pass`  out  1  every hart PASS

## Operation
- Per-hart FSM: IDLE(0) → RUN(1) on `start`; RUN → PASS(2) / FAIL(3) on `ecall`; RUN → TIMEOUT(4) when counter reaches `TIMEOUT`; RUN → STALL(5) (macro only). Terminal states hold until `start` or reset.
- Shadow: on `wb_en && wb_addr==RESULT_REG`, shadow ← `wb_data`. Writes to x0 ignored. Shadow is updated in every state and cleared on `start`.
- Verdict on `ecall`: effective value = same-cycle write to `RESULT_REG` if present (bypass), else shadow. Value==1 → PASS; else FAIL with `fail_testnum` = value[XLEN-1:1]; PASS sets `fail_testnum`=0.
- Counter: cleared on `start`, +1 per cycle in RUN, frozen in terminal states, never wraps.
- `ecall` in IDLE or terminal states ignored. `ecall` in the cycle the counter reaches `TIMEOUT`: ecall wins.
- `start` in any state: restart (counter 0, shadow 0, RUN). `start` with same-cycle `ecall`: `start` wins.
- `all_done`/`all_pass` are combinational over registered `status`; both 0 while any hart is IDLE.

## Timing
- Reset values: `status`=0 (IDLE), `fail_testnum`=0, `cycles`=0, `all_done`=0, `all_pass`=0; shadow and counters 0.
- `start` at edge k → `status`=RUN after edge k; `cycles` counts from 0 at edge k.
- `ecall` sampled at edge n → verdict visible after edge n (1-cycle latency); `cycles` = n−k.
- TIMEOUT asserted after the edge at which the counter would exceed `TIMEOUT`−1; `cycles`=`TIMEOUT`.
- Reset assertion mid-run forces all outputs to reset values immediately (asynchronous).

## Configuration
- `RISCV_TEST_MONITOR_STALL_DETECT_EN` defined: per-hart stall counter, cleared when `pc` changes or on `start`; reaching `STALL_CYCLES` in RUN → STALL(5), `cycles` latched. Ecall in the same cycle wins.
- Undefined: no stall logic; `pc` unused; code 5 never produced.

## Structure
- Package `riscv_test_monitor_pkg`: status codes IDLE..STALL as 3-bit constants, `RESULT_REG` default, status width constant.
- Sub-module `riscv_test_monitor_hart`: one FSM + shadow + counters; top generates `NHARTS` instances and reduces `all_done`/`all_pass`.

## Test plan
- Reset, `start`, write gp=1, ecall 10 cycles later → PASS, `cycles`=10, `fail_testnum`=0, `all_pass`=1.
- Write gp=0x0000000B, ecall → FAIL, `fail_testnum`=5; gp=1 written in the same cycle as ecall (after gp=7 earlier) → PASS.
- `TIMEOUT`=20, no ecall → TIMEOUT after 20 cycles, `cycles`=20; ecall in the boundary cycle → verdict, not TIMEOUT.
- `NHARTS`=2: hart0 PASS, hart1 FAIL testnum 3 → `all_done`=1, `all_pass`=0; `all_done`=0 while hart1 still RUN.
- Reset pulled low mid-RUN → all outputs 0 asynchronously; `start` after terminal state → RUN, counter 0, shadow 0.
- Macro on, `STALL_CYCLES`=8, `pc` held constant in RUN → STALL after 8 cycles; macro off, same stimulus → remains RUN until TIMEOUT.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_monitor_pkg: shared status codes and defaults for the
// riscv-tests completion monitor.
package riscv_test_monitor_pkg;

  localparam int ST_W = 3;
  localparam int RESULT_REG_DEF = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_STALL   = 3'd5
  } status_e;

endpackage

// File: rtl/riscv_test_monitor_hart.sv
// riscv_test_monitor_hart: per-hart verdict FSM, gp shadow, cycle counter.
// Stall detection is built only with RISCV_TEST_MONITOR_STALL_DETECT_EN.
module riscv_test_monitor_hart
  import riscv_test_monitor_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESULT_REG   = RESULT_REG_DEF,
  parameter int TIMEOUT      = 5000,
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
  parameter int STALL_CYCLES = 64,
`endif
  parameter int CW           = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ecall,
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
  input  logic [XLEN-1:0] pc,
`endif
  output logic [ST_W-1:0] status,
  output logic [XLEN-2:0] fail_testnum,
  output logic [CW-1:0]   cycles
);

  localparam logic [4:0]    RES_A  = 5'(RESULT_REG);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  status_e         st_q, st_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [XLEN-2:0] tn_q, tn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] eff;
  logic            hit;
  logic            stalled;

  assign hit = wb_en && (wb_addr == RES_A) && (wb_addr != 5'd0);
  assign eff = hit ? wb_data : sh_q;

`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_CYCLES);

  logic [XLEN-1:0] pc_q;
  logic [SW-1:0]   stl_q, stl_d;

  always_comb begin
    stl_d = stl_q;
    if (start || pc != pc_q) stl_d = '0;
    else if (st_q == ST_RUN) stl_d = stl_q + SW'(1);
  end

  assign stalled = (st_q == ST_RUN) && (stl_d == STALL_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      stl_q <= '0;
    end else begin
      pc_q  <= pc;
      stl_q <= stl_d;
    end
  end
`else
  assign stalled = 1'b0;
`endif

  // Priority in RUN: ecall, then timeout, then stall.
  always_comb begin
    st_d  = st_q;
    sh_d  = hit ? wb_data : sh_q;
    tn_d  = tn_q;
    cnt_d = cnt_q;
    if (start) begin
      st_d  = ST_RUN;
      sh_d  = '0;
      tn_d  = '0;
      cnt_d = '0;
    end else if (st_q == ST_RUN) begin
      cnt_d = cnt_q + CW'(1);
      if (ecall) begin
        if (eff == XLEN'(1)) begin
          st_d = ST_PASS;
          tn_d = '0;
        end else begin
          st_d = ST_FAIL;
          tn_d = eff[XLEN-1:1];
        end
      end else if (cnt_d == TO_LIM) begin
        st_d = ST_TIMEOUT;
        tn_d = sh_q[XLEN-1:1];
      end else if (stalled) begin
        st_d = ST_STALL;
        tn_d = sh_q[XLEN-1:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_IDLE;
      sh_q  <= '0;
      tn_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      sh_q  <= sh_d;
      tn_q  <= tn_d;
      cnt_q <= cnt_d;
    end
  end

  assign status       = st_q;
  assign fail_testnum = tn_q;
  assign cycles       = cnt_q;

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: NHARTS verdict monitors plus done/pass reduction.
// Optional stall detection: RISCV_TEST_MONITOR_STALL_DETECT_EN.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int NHARTS       = 1,
  parameter int XLEN         = 32,
  parameter int RESULT_REG   = RESULT_REG_DEF,
  parameter int TIMEOUT      = 5000,
  parameter int STALL_CYCLES = 64,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NHARTS-1:0]        wb_en,
  input  logic [NHARTS*5-1:0]      wb_addr,
  input  logic [NHARTS*XLEN-1:0]   wb_data,
  input  logic [NHARTS-1:0]        ecall,
  input  logic [NHARTS*XLEN-1:0]   pc,
  output logic [NHARTS*ST_W-1:0]   status,
  output logic [NHARTS*(XLEN-1)-1:0] fail_testnum,
  output logic [NHARTS*CW-1:0]     cycles,
  output logic                     all_done,
  output logic                     all_pass
);

`ifndef RISCV_TEST_MONITOR_STALL_DETECT_EN
  localparam int stall_cycles_unused = STALL_CYCLES;
  logic pc_unused;
  assign pc_unused = ^pc;
`endif

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    riscv_test_monitor_hart #(
      .XLEN        (XLEN),
      .RESULT_REG  (RESULT_REG),
      .TIMEOUT     (TIMEOUT),
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
      .STALL_CYCLES(STALL_CYCLES),
`endif
      .CW          (CW)
    ) u_hart (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .wb_en       (wb_en[h]),
      .wb_addr     (wb_addr[h*5 +: 5]),
      .wb_data     (wb_data[h*XLEN +: XLEN]),
      .ecall       (ecall[h]),
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
      .pc          (pc[h*XLEN +: XLEN]),
`endif
      .status      (status[h*ST_W +: ST_W]),
      .fail_testnum(fail_testnum[h*(XLEN-1) +: (XLEN-1)]),
      .cycles      (cycles[h*CW +: CW])
    );
  end

  // Terminal codes are everything from PASS upward.
  always_comb begin
    all_done = 1'b1;
    all_pass = 1'b1;
    for (int h = 0; h < NHARTS; h++) begin
      if (status[h*ST_W +: ST_W] < ST_PASS) all_done = 1'b0;
      if (status[h*ST_W +: ST_W] != ST_PASS) all_pass = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed literal checks plus random traffic
// compared every cycle against an elapsed-time reference model.
module tb_riscv_test_monitor;

  localparam int NH = 2;
  localparam int XL = 32;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int CW = $clog2(TO + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [NH-1:0]        wb_en = '0;
  logic [NH*5-1:0]      wb_addr = '0;
  logic [NH*XL-1:0]     wb_data = '0;
  logic [NH-1:0]        ecall = '0;
  logic [NH*XL-1:0]     pc = '0;
  logic [NH*3-1:0]      status;
  logic [NH*(XL-1)-1:0] fail_testnum;
  logic [NH*CW-1:0]     cycles;
  logic                 all_done;
  logic                 all_pass;

  riscv_test_monitor #(
    .NHARTS(NH), .XLEN(XL), .RESULT_REG(3),
    .TIMEOUT(TO), .STALL_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ecall(ecall), .pc(pc), .status(status),
    .fail_testnum(fail_testnum), .cycles(cycles),
    .all_done(all_done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: time-stamped start, elapsed-time verdicts.
  int              now = 0;
  int              m_st [NH];
  int              m_t0 [NH];
  int              m_cy [NH];
  int              m_pcc[NH];
  logic [XL-1:0]   m_sh [NH];
  logic [XL-2:0]   m_tn [NH];
  logic [XL-1:0]   m_pcp[NH];
  logic            t_hit;
  logic [XL-1:0]   t_d, t_v, t_old, t_pc;
  int              t_el, t_base;

  initial begin
    for (int h = 0; h < NH; h++) begin
      m_st[h] = 0; m_t0[h] = 0; m_cy[h] = 0; m_pcc[h] = 0;
      m_sh[h] = '0; m_tn[h] = '0; m_pcp[h] = '0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      now = 0;
      for (int h = 0; h < NH; h++) begin
        m_st[h] = 0; m_t0[h] = 0; m_cy[h] = 0; m_pcc[h] = 0;
        m_sh[h] = '0; m_tn[h] = '0; m_pcp[h] = '0;
      end
    end else begin
      now++;
      for (int h = 0; h < NH; h++) begin
        t_d   = wb_data[h*XL +: XL];
        t_pc  = pc[h*XL +: XL];
        t_hit = wb_en[h] && wb_addr[h*5 +: 5] == 5'd3;
        t_old = m_sh[h];
        if (t_pc != m_pcp[h]) m_pcc[h] = now;
        m_pcp[h] = t_pc;
        if (t_hit) m_sh[h] = t_d;
        if (start) begin
          m_st[h] = 1; m_t0[h] = now; m_sh[h] = '0;
          m_tn[h] = '0; m_cy[h] = 0;
        end else if (m_st[h] == 1) begin
          t_el   = now - m_t0[h];
          t_v    = t_hit ? t_d : t_old;
          t_base = (m_pcc[h] > m_t0[h]) ? m_pcc[h] : m_t0[h];
          if (ecall[h]) begin
            m_st[h] = (t_v == 1) ? 2 : 3;
            m_tn[h] = (t_v == 1) ? '0 : t_v[XL-1:1];
            m_cy[h] = t_el;
          end else if (t_el == TO) begin
            m_st[h] = 4; m_tn[h] = t_old[XL-1:1]; m_cy[h] = t_el;
          end
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
          else if (now - t_base == SC) begin
            m_st[h] = 5; m_tn[h] = t_old[XL-1:1]; m_cy[h] = t_el;
          end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_done, e_pass;
      e_done = 1'b1;
      e_pass = 1'b1;
      for (int h = 0; h < NH; h++) begin
        chk("status", 64'(status[h*3 +: 3]), 64'(m_st[h]));
        chk("testnum", 64'(fail_testnum[h*(XL-1) +: XL-1]),
            64'(m_tn[h]));
        chk("cycles", 64'(cycles[h*CW +: CW]),
            64'((m_st[h] == 1) ? now - m_t0[h] : m_cy[h]));
        if (m_st[h] < 2) e_done = 1'b0;
        if (m_st[h] != 2) e_pass = 1'b0;
      end
      chk("all_done", 64'(all_done), 64'(e_done));
      chk("all_pass", 64'(all_pass), 64'(e_pass));
    end
  end

  task automatic clr();
    start = 1'b0; wb_en = '0; ecall = '0;
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(negedge clk);
      clr();
    end
  endtask

  task automatic wr(input int h, input logic [XL-1:0] d);
    wb_en[h] = 1'b1;
    wb_addr[h*5 +: 5] = 5'd3;
    wb_data[h*XL +: XL] = d;
  endtask

  task automatic lit(input string nm, input int h, input int st,
                     input int tn, input int cy);
    chk({nm, ".st"}, 64'(status[h*3 +: 3]), 64'(st));
    chk({nm, ".tn"}, 64'(fail_testnum[h*(XL-1) +: XL-1]), 64'(tn));
    chk({nm, ".cy"}, 64'(cycles[h*CW +: CW]), 64'(cy));
  endtask

  initial begin
    chk_en = 1'b1;
    go(3);
    lit("rst0", 0, 0, 0, 0);
    lit("rst1", 1, 0, 0, 0);
    chk("rst.done", 64'(all_done), 64'(0));
    chk("rst.pass", 64'(all_pass), 64'(0));
    rst = 1'b1;
    go(1);

    start = 1'b1; go(1);
    lit("run", 0, 1, 0, 0);
    wr(0, 1); go(1);
    go(8);
    ecall[0] = 1'b1; go(1);
    lit("pass10", 0, 2, 0, 10);
    chk("h1run.done", 64'(all_done), 64'(0));
    wr(1, 7); ecall[1] = 1'b1; go(1);
    lit("bypfail", 1, 3, 3, 11);
    chk("mix.done", 64'(all_done), 64'(1));
    chk("mix.pass", 64'(all_pass), 64'(0));

    start = 1'b1; go(1);
    wr(0, 32'h0000000B); wr(1, 7); go(1);
    ecall = 2'b11; wr(1, 1); go(1);
    lit("fail5", 0, 3, 5, 2);
    lit("byppass", 1, 2, 0, 2);

    start = 1'b1; go(1);
    wr(0, 1); wr(1, 1); ecall = 2'b11; go(1);
    chk("both.pass", 64'(all_pass), 64'(1));
    ecall = 2'b11; wr(0, 9); go(1);
    lit("ignore", 0, 2, 0, 1);

    start = 1'b1; go(1);
    go(19);
    lit("pre_to", 1, 1, 0, 19);
    ecall[0] = 1'b1; go(1);
    lit("edge_ec", 0, 3, 0, 20);
    lit("timeout", 1, 4, 0, 20);

    start = 1'b1; go(1);
    go(3);
    #2 rst = 1'b0;
    #1 lit("arst", 0, 0, 0, 0);
    chk("arst.done", 64'(all_done), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    clr();

    wr(0, 1); start = 1'b1; ecall = 2'b11; go(1);
    lit("st_ec", 0, 1, 0, 0);
    go(7);
    lit("pre_stl", 0, 1, 0, 7);
    go(1);
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
    lit("stall", 0, 5, 0, 8);
`else
    lit("nostall", 0, 1, 0, 8);
    go(12);
    lit("stl_to", 0, 4, 0, 20);
`endif

    repeat (3000) begin
      clr();
      start = ($urandom % 40) == 0;
      for (int h = 0; h < NH; h++) begin
        wb_en[h] = ($urandom % 3) == 0;
        case ($urandom % 3)
          0: wb_addr[h*5 +: 5] = 5'd3;
          1: wb_addr[h*5 +: 5] = 5'd0;
          default: wb_addr[h*5 +: 5] = 5'($urandom % 32);
        endcase
        case ($urandom % 4)
          0: wb_data[h*XL +: XL] = 32'd1;
          1: wb_data[h*XL +: XL] = 32'd0;
          2: wb_data[h*XL +: XL] = 32'($urandom % 16);
          default: wb_data[h*XL +: XL] = $urandom;
        endcase
        ecall[h] = ($urandom % 12) == 0;
        if (($urandom % 4) == 0) pc[h*XL +: XL] = 32'($urandom % 4);
      end
      @(negedge clk);
      if (($urandom % 400) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    clr();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
